// File: rtl/calc1_port_driver.sv
// calc1_port_driver
// Upstream request sequencer for one calc1 port. Takes a complete operation
// (cmd, operand1, operand2) over valid/ready. Drives it onto calc1's two-cycle
// request protocol: command + operand1, then operand2. Waits for calc1's
// response and presents response code and result over a valid/ready result
// interface. Only one operation is outstanding at a time.
//
// Build option: define CALC1_DRV_TIMEOUT_EN to add a saturating watchdog.
// The watchdog forces a timeout result (resp 3) TIMEOUT edges after accept
// if calc1 stays silent. Without it, the driver waits indefinitely for calc1.
module calc1_port_driver #(
    parameter int DATA_W  = 32,
    parameter int CMD_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [CMD_W-1:0]  op_cmd,
    input  logic [DATA_W-1:0] op_data1,
    input  logic [DATA_W-1:0] op_data2,
    output logic [CMD_W-1:0]  req_cmd_out,
    output logic [DATA_W-1:0] req_data_out,
    input  logic [1:0]        calc_resp,
    input  logic [DATA_W-1:0] calc_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [1:0]        res_resp,
    output logic [DATA_W-1:0] res_data,
    output logic              busy
);

    // Response codes presented on res_resp.
    localparam logic [1:0] RESP_OK      = 2'd1;
    localparam logic [1:0] RESP_ERR     = 2'd2;
    localparam logic [1:0] RESP_TIMEOUT = 2'd3;

    // The watchdog counter is 8 bits wide, so TIMEOUT-1 must fit in it.
    if (TIMEOUT < 2 || TIMEOUT > 256) begin : g_bad_timeout
        $error("calc1_port_driver: TIMEOUT must be in 2..256");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_OPND = 3'd2,
        ST_WAIT = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic              op_ready_reg,  op_ready_next;
    logic [CMD_W-1:0]  req_cmd_reg,   req_cmd_next;
    logic [DATA_W-1:0] req_data_reg,  req_data_next;
    logic [DATA_W-1:0] op2_reg,       op2_next;
    logic              res_valid_reg, res_valid_next;
    logic [1:0]        res_resp_reg,  res_resp_next;
    logic [DATA_W-1:0] res_data_reg,  res_data_next;
    logic              busy_reg,      busy_next;

    logic accept;
    logic in_flight;
    logic resp_hit;
    logic timeout_hit;

    // An accept needs the registered op_ready, which is only high in IDLE.
    assign accept    = op_valid && op_ready_reg && (state_reg == ST_IDLE);
    assign in_flight = (state_reg == ST_CMD) || (state_reg == ST_OPND) ||
                       (state_reg == ST_WAIT);
    assign resp_hit  = in_flight && (calc_resp != 2'd0);

`ifdef CALC1_DRV_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wdog_reg, wdog_next;

    // Watchdog: cleared on accept, counts (saturating) while calc1 owes a response.
    always_comb begin
        wdog_next = wdog_reg;
        if (accept) begin
            wdog_next = 8'd0;
        end else if (in_flight && (wdog_reg != 8'hFF)) begin
            wdog_next = wdog_reg + 8'd1;
        end
    end

    // Watchdog register.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            wdog_reg <= 8'd0;
        end else begin
            wdog_reg <= wdog_next;
        end
    end

    assign timeout_hit = in_flight && (wdog_reg == TIMEOUT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and next-output logic. Response capture outranks the timeout.
    // The timeout in turn outranks the normal CMD->OPND->WAIT progression.
    always_comb begin
        state_next     = state_reg;
        req_cmd_next   = req_cmd_reg;
        req_data_next  = req_data_reg;
        op2_next       = op2_reg;
        res_valid_next = res_valid_reg;
        res_resp_next  = res_resp_reg;
        res_data_next  = res_data_reg;

        case (state_reg)
            ST_IDLE: begin
                req_cmd_next  = '0;
                req_data_next = '0;
                if (accept) begin
                    if (op_cmd != '0) begin
                        req_cmd_next  = op_cmd;
                        req_data_next = op_data1;
                        op2_next      = op_data2;
                        state_next    = ST_CMD;
                    end else begin
                        // Command 0 is rejected locally; calc1 never sees it.
                        res_valid_next = 1'b1;
                        res_resp_next  = RESP_ERR;
                        res_data_next  = '0;
                        state_next     = ST_HOLD;
                    end
                end
            end

            ST_CMD, ST_OPND, ST_WAIT: begin
                if (resp_hit) begin
                    res_valid_next = 1'b1;
                    res_resp_next  = calc_resp;
                    res_data_next  = (calc_resp == RESP_OK) ? calc_data : '0;
                    req_cmd_next   = '0;
                    req_data_next  = '0;
                    state_next     = ST_HOLD;
                end else if (timeout_hit) begin
                    res_valid_next = 1'b1;
                    res_resp_next  = RESP_TIMEOUT;
                    res_data_next  = '0;
                    req_cmd_next   = '0;
                    req_data_next  = '0;
                    state_next     = ST_HOLD;
                end else if (state_reg == ST_CMD) begin
                    req_cmd_next  = '0;
                    req_data_next = op2_reg;
                    state_next    = ST_OPND;
                end else if (state_reg == ST_OPND) begin
                    req_data_next = '0;
                    state_next    = ST_WAIT;
                end else begin
                    req_cmd_next  = '0;
                    req_data_next = '0;
                end
            end

            ST_HOLD: begin
                // Late or spurious calc1 responses are ignored here.
                if (res_ready) begin
                    res_valid_next = 1'b0;
                    res_resp_next  = 2'd0;
                    res_data_next  = '0;
                    state_next     = ST_IDLE;
                end
            end

            default: begin
                req_cmd_next   = '0;
                req_data_next  = '0;
                res_valid_next = 1'b0;
                res_resp_next  = 2'd0;
                res_data_next  = '0;
                state_next     = ST_IDLE;
            end
        endcase

        // Registered status follows the state being entered, so both
        // reflect the current state in the cycle after each edge.
        op_ready_next = (state_next == ST_IDLE);
        busy_next     = (state_next != ST_IDLE);
    end

    // State and output registers; reset drops any in-flight operation.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            op_ready_reg  <= 1'b0;
            req_cmd_reg   <= '0;
            req_data_reg  <= '0;
            op2_reg       <= '0;
            res_valid_reg <= 1'b0;
            res_resp_reg  <= 2'd0;
            res_data_reg  <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_ready_reg  <= op_ready_next;
            req_cmd_reg   <= req_cmd_next;
            req_data_reg  <= req_data_next;
            op2_reg       <= op2_next;
            res_valid_reg <= res_valid_next;
            res_resp_reg  <= res_resp_next;
            res_data_reg  <= res_data_next;
            busy_reg      <= busy_next;
        end
    end

    assign op_ready     = op_ready_reg;
    assign req_cmd_out  = req_cmd_reg;
    assign req_data_out = req_data_reg;
    assign res_valid    = res_valid_reg;
    assign res_resp     = res_resp_reg;
    assign res_data     = res_data_reg;
    assign busy         = busy_reg;

endmodule
